// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: digit selects, FSM states and the digit decoder.
package booth_pkg;

    typedef enum logic [2:0] {
        B_ZERO,
        B_POS1,
        B_POS2,
        B_NEG2,
        B_NEG1
    } booth_sel_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } mul_state_t;

    // bits = {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_sel_t booth_decode(input logic [2:0] bits);
        booth_sel_t sel;
        case (bits)
            3'b001, 3'b010: sel = B_POS1;
            3'b011:         sel = B_POS2;
            3'b100:         sel = B_NEG2;
            3'b101, 3'b110: sel = B_NEG1;
            default:        sel = B_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational Booth partial-product generator: 0, +-A or +-2A on a (WIDTH+2)-bit path.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  booth_sel_t         i_sel,
    input  logic [WIDTH+1:0]   i_a,
    output logic [WIDTH+1:0]   o_pp
);

    localparam logic [WIDTH+1:0] PP_ONE = {{(WIDTH+1){1'b0}}, 1'b1};

    logic [WIDTH+1:0] w_a2;

    assign w_a2 = {i_a[WIDTH:0], 1'b0};

    always_comb begin
        o_pp = '0;
        case (i_sel)
            B_POS1:  o_pp = i_a;
            B_POS2:  o_pp = w_a2;
            B_NEG2:  o_pp = (~w_a2) + PP_ONE;
            B_NEG1:  o_pp = (~i_a) + PP_ONE;
            default: o_pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Define BOOTH_MULT_UNSIGNED_EN to add the in_signed input for unsigned operation.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef BOOTH_MULT_UNSIGNED_EN
    input  logic                 in_signed,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

`ifdef BOOTH_MULT_UNSIGNED_EN
    localparam int unsigned BW = WIDTH + 2;
`else
    localparam int unsigned BW = WIDTH;
`endif
    // One spare bit on the upper slice keeps the unsigned running sum from wrapping.
    localparam int unsigned HW = WIDTH + 3;
    localparam int unsigned AW = HW + BW;
    localparam int unsigned CW = $clog2(BW / 2 + 1);

    mul_state_t           r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [WIDTH+1:0]     r_a;
    logic [BW:0]          r_b;
    logic [AW-1:0]        r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_p;
`ifdef BOOTH_MULT_UNSIGNED_EN
    logic                 r_signed;
`endif

    logic                 w_sgn;
    logic [WIDTH+1:0]     w_a_ext;
    logic [BW-1:0]        w_b_ext;
    booth_sel_t           w_sel;
    logic [WIDTH+1:0]     w_pp;
    logic [HW-1:0]        w_sum;
    logic signed [AW-1:0] w_cat;
    logic [AW-1:0]        w_acc_next;
    logic [CW-1:0]        w_nstep;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_prod;

`ifdef BOOTH_MULT_UNSIGNED_EN
    assign w_sgn   = in_signed;
    assign w_b_ext = {{2{in_b[WIDTH-1] & w_sgn}}, in_b};
    assign w_nstep = r_signed ? CW'(WIDTH / 2) : CW'(WIDTH / 2 + 1);
    // Signed ops stop one digit early, so the product sits two bits higher.
    assign w_prod  = r_signed ? w_acc_next[2*WIDTH+1:2] : w_acc_next[2*WIDTH-1:0];
`else
    assign w_sgn   = 1'b1;
    assign w_b_ext = in_b;
    assign w_nstep = CW'(WIDTH / 2);
    assign w_prod  = w_acc_next[2*WIDTH-1:0];
`endif

    assign w_a_ext = {{2{in_a[WIDTH-1] & w_sgn}}, in_a};
    assign w_sel   = booth_decode(r_b[2:0]);

    booth_pp_gen #(
        .WIDTH (WIDTH)
    ) u_pp_gen (
        .i_sel (w_sel),
        .i_a   (r_a),
        .o_pp  (w_pp)
    );

    assign w_sum      = r_acc[AW-1 -: HW] + {w_pp[WIDTH+1], w_pp};
    assign w_cat      = {w_sum, r_acc[BW-1:0]};
    assign w_acc_next = w_cat >>> 2;
    assign w_last     = (r_cnt == w_nstep - CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_p         <= '0;
`ifdef BOOTH_MULT_UNSIGNED_EN
            r_signed    <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= w_a_ext;
                        r_b        <= {w_b_ext, 1'b0};
                        r_acc      <= '0;
                        r_cnt      <= '0;
`ifdef BOOTH_MULT_UNSIGNED_EN
                        r_signed   <= in_signed;
`endif
                        r_in_ready <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_b   <= {r_b[BW], r_b[BW], r_b[BW:2]};
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_p         <= w_prod;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_p     = r_p;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq (WIDTH=32); define BOOTH_MULT_UNSIGNED_EN to test unsigned mode.
module tb_booth_mult_seq;

    localparam int unsigned W = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_p;
`ifdef BOOTH_MULT_UNSIGNED_EN
    logic            in_signed;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef BOOTH_MULT_UNSIGNED_EN
        .in_signed (in_signed),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle 1 is the accept cycle; the returned count is the cycle in which out_valid is first seen.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input int exp_lat, input int stall);
        int lat;
        bit seen;
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            lat++;
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_valid_seen"}, {63'd0, seen}, 64'd1);
        if (exp_lat > 0) check({tag, "_latency"}, 64'(lat - 1), 64'(exp_lat));
        check({tag, "_prod"}, out_p, exp);
        for (int i = 0; i < stall; i++) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    initial begin
        logic [2*W-1:0] held;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
`ifdef BOOTH_MULT_UNSIGNED_EN
        in_signed = 1'b1;
`endif
        repeat (2) @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_p", out_p, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("7x-3", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 17, 0);
        run_op("min_x_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 17, 0);
        run_op("min_x_m1", 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 1);
        run_op("max_x_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 0, 0);
        run_op("min_x_max", 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 0, 2);
        run_op("x_x_0", 32'h1234_5678, 32'd0, 64'd0, 0, 0);
        run_op("x_x_m1", 32'h1234_5678, 32'hFFFF_FFFF, 64'hFFFF_FFFF_EDCB_A988, 0, 0);
        run_op("m1_x_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 0, 0);

        // Stall in DONE while a competing request is offered.
        in_a     = 32'd1000;
        in_b     = 32'd1000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
        held     = out_p;
        check("stall_prod", held, 64'd1000000);
        in_a     = 32'd3;
        in_b     = 32'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hold_p", out_p, held);
            check("stall_hold_flags", {62'd0, in_ready, out_valid}, 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stall_release", {62'd0, in_ready, out_valid}, 64'd2);
        run_op("after_stall", 32'hFFFF_FFFE, 32'd9, 64'hFFFF_FFFF_FFFF_FFEE, 17, 0);

        // Reset in the fifth CALC cycle drops the product in flight.
        in_a     = 32'd11;
        in_b     = 32'd13;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_flags", {62'd0, in_ready, out_valid}, 64'd2);
        check("midrst_out_p", out_p, 64'd0);
        repeat (20) @(negedge clk);
        check("midrst_no_valid", {63'd0, out_valid}, 64'd0);
        run_op("5x6", 32'd5, 32'd6, 64'd30, 17, 0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op("rand", ra, rb, {{W{ra[W-1]}}, ra} * {{W{rb[W-1]}}, rb}, 0, $urandom_range(0, 3));
        end

`ifdef BOOTH_MULT_UNSIGNED_EN
        in_signed = 1'b0;
        run_op("uns_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 18, 0);
        run_op("uns_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 18, 0);
        in_signed = 1'b1;
        run_op("sgn_again", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 17, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
